// File: rtl/gt_direct_map_cache.sv
// Direct-mapped, read-allocate cache: byte-wide lookups against 256-bit lines,
// filling from memData on a miss and presenting the evicted line on toMemData.
module gt_direct_map_cache #(
  parameter int INDEX_BITS  = 3,
  parameter int OFFSET_BITS = 5,
  parameter int ADDR_BITS   = 32
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  input  logic [ADDR_BITS-1:0]          nextAddr,
  input  logic [(8<<OFFSET_BITS)-1:0]   memData,
  output logic [7:0]                    dataReturn,
  output logic                          hit,
  output logic [(8<<OFFSET_BITS)-1:0]   toMemData
);

  localparam int LINES     = 2 ** INDEX_BITS;
  localparam int LINE_BITS = 8 << OFFSET_BITS;
  localparam int TAG_BITS  = ADDR_BITS - OFFSET_BITS - INDEX_BITS;

  logic [LINES-1:0]     validBits;
  logic [TAG_BITS-1:0]  tagStore  [LINES];
  logic [LINE_BITS-1:0] dataStore [LINES];

  logic [OFFSET_BITS-1:0] offset;
  logic [INDEX_BITS-1:0]  index;
  logic [TAG_BITS-1:0]    tag;
  logic                   hitC;
  logic [LINE_BITS-1:0]   storedLine;
  logic [LINE_BITS-1:0]   srcLine;
  logic [7:0]             byteSel;

  assign offset = nextAddr[OFFSET_BITS-1:0];
  assign index  = nextAddr[OFFSET_BITS+INDEX_BITS-1:OFFSET_BITS];
  assign tag    = nextAddr[ADDR_BITS-1:OFFSET_BITS+INDEX_BITS];

  assign storedLine = dataStore[index];
  assign hitC       = validBits[index] && (tagStore[index] == tag);

  // On a miss the requested byte comes straight from the fill data.
  assign srcLine = hitC ? storedLine : memData;
  assign byteSel = srcLine[{offset, 3'b000} +: 8];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of hitC/validBits in the same clock edge.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      validBits  <= '0;
      hit        <= 1'b0;
      dataReturn <= '0;
      toMemData  <= '0;
    end else begin
      hit        <= hitC;
      dataReturn <= byteSel;
      if (hitC) begin
        toMemData <= '0;
      end else begin
        toMemData        <= validBits[index] ? storedLine : '0;
        validBits[index] <= 1'b1;
      end
    end
  end

  // NOTE: tag and data arrays carry no reset; the cleared valid bits already
  // make their contents irrelevant, and leaving them unreset lets them map to RAM.
  always_ff @(posedge CLK) begin
    if (!hitC) begin
      tagStore[index]  <= tag;
      dataStore[index] <= memData;
    end
  end

endmodule

// File: tb/tb_gt_direct_map_cache.sv
// Directed self-checking bench for gt_direct_map_cache: fills, evictions, hits,
// offset extremes and asynchronous reset mid-operation.
module tb_gt_direct_map_cache;

  localparam logic [255:0] P =
    256'hFFFF_EEEE_DDDD_CCCC_BBBB_AAAA_9999_8888_7777_6666_5555_4444_3333_2222_1111_0000;

  logic         CLK;
  logic         RST_N;
  logic [31:0]  nextAddr;
  logic [255:0] memData;
  logic [7:0]   dataReturn;
  logic         hit;
  logic [255:0] toMemData;

  int checks = 0;
  int errors = 0;

  gt_direct_map_cache dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .nextAddr   (nextAddr),
    .memData    (memData),
    .dataReturn (dataReturn),
    .hit        (hit),
    .toMemData  (toMemData)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [255:0] observed,
                       input logic [255:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Present one request, clock it, and check the registered outputs.
  task automatic step(input string tag, input logic [31:0] addr,
                      input logic expHit, input logic [7:0] expData,
                      input logic [255:0] expVictim);
    nextAddr = addr;
    @(posedge CLK);
    #1;
    check({tag, ".hit"}, {255'd0, hit}, {255'd0, expHit});
    check({tag, ".data"}, {248'd0, dataReturn}, {248'd0, expData});
    check({tag, ".victim"}, toMemData, expVictim);
  endtask

  initial begin
    RST_N    = 1'b0;
    memData  = P;
    nextAddr = 32'h0010_0001;
    @(posedge CLK);
    #1;
    check("reset.hit", {255'd0, hit}, 256'd0);
    check("reset.data", {248'd0, dataReturn}, 256'd0);
    check("reset.victim", toMemData, 256'd0);
    RST_N = 1'b1;

    step("t1_cold",     32'h0010_0001, 1'b0, 8'h00, 256'd0);
    step("t2_conflict", 32'h0020_0002, 1'b0, 8'h11, P);
    step("t3_conflict", 32'h0030_0003, 1'b0, 8'h11, P);
    step("t3_idx7",     32'h0230_00F3, 1'b0, 8'h99, 256'd0);

    memData = '0;
    step("t4_hit",      32'h0030_0003, 1'b1, 8'h11, 256'd0);
    step("t5_evict",    32'h0020_0002, 1'b0, 8'h00, P);
    step("t5_rehit",    32'h0020_0002, 1'b1, 8'h00, 256'd0);
    step("t5_hold",     32'h0020_0002, 1'b1, 8'h00, 256'd0);
    step("idx7_hit",    32'h0230_00F3, 1'b1, 8'h99, 256'd0);
    step("idx7_off31",  32'h0230_00FF, 1'b1, 8'hFF, 256'd0);

    // Asynchronous reset between edges clears outputs without a clock edge.
    #2;
    RST_N = 1'b0;
    #1;
    check("async.hit", {255'd0, hit}, 256'd0);
    check("async.data", {248'd0, dataReturn}, 256'd0);
    check("async.victim", toMemData, 256'd0);
    @(posedge CLK);
    #1;
    RST_N   = 1'b1;
    memData = P;

    step("t6_after",    32'h0030_0003, 1'b0, 8'h11, 256'd0);
    step("t6_rehit",    32'h0030_0003, 1'b1, 8'h11, 256'd0);
    step("t6_idx7",     32'h0230_00FF, 1'b0, 8'hFF, 256'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
